// File: rtl/cache_mem_interface_if.sv
// Memory-side bus of cache_mem_interface: a valid/ready beat request channel
// plus a read-response channel. The master is the line mover and the slave is main memory.
interface cache_mem_interface_if #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0]  mem_wdata;
  logic                  mem_rvalid;
  logic [BUS_WIDTH-1:0]  mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_mem_interface.sv
// cache_mem_interface: moves one cache line between cache_controller and main
// memory as BEATS bus beats. It performs either a dirty-line write-back or a line refill.
// Optional build macro MEM_TIMEOUT_EN adds a per-beat watchdog and a sticky
// mem_error output. Without it, the block waits indefinitely on memory.
module cache_mem_interface #(
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] wb_line,
  output logic                  ready_mem,
  output logic [LINE_WIDTH-1:0] refill_line,
`ifdef MEM_TIMEOUT_EN
  output logic                  mem_error,
`endif
  cache_mem_interface_if.master bus
);
  localparam int unsigned BEATS      = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned BEAT_BYTES = BUS_WIDTH / 8;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned OFF_W      = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {StIdle, StWbReq, StRfReq, StRfWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] refill_q, refill_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  int unsigned           slice_lo;
  logic                  last_beat;

  // Base is line-aligned, so beat offsets never carry out of the line
  assign beat_addr   = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);
  assign slice_lo    = 32'(beat_q) * BUS_WIDTH;
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  assign refill_line = refill_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            busy, beat_hs;

  assign busy      = (state_q == StWbReq) || (state_q == StRfReq) || (state_q == StRfWait);
  assign beat_hs   = (((state_q == StWbReq) || (state_q == StRfReq)) && bus.mem_req_ready) ||
                     ((state_q == StRfWait) && bus.mem_rvalid);
  assign mem_error = err_q;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      base_q   <= '0;
      line_q   <= '0;
      refill_q <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      line_q   <= line_d;
      refill_q <= refill_d;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic and Moore outputs; bus payload is zero outside request states
  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    base_d            = base_q;
    line_d            = line_q;
    refill_d          = refill_q;
    ready_mem         = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
`ifdef MEM_TIMEOUT_EN
    to_cnt_d          = '0;
    err_d             = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Write-back wins when both requests are present
        if (write_en_mem) begin
          base_d  = line_addr & ~OFF_MASK;
          line_d  = wb_line;
          beat_d  = '0;
          state_d = StWbReq;
        end else if (read_en_mem) begin
          base_d  = line_addr & ~OFF_MASK;
          beat_d  = '0;
          state_d = StRfReq;
        end
      end
      StWbReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = 1'b1;
        bus.mem_addr      = beat_addr;
        bus.mem_wdata     = line_q[slice_lo +: BUS_WIDTH];
        if (bus.mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = StDone;
        end
      end
      StRfReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = beat_addr;
        if (bus.mem_req_ready) state_d = StRfWait;
      end
      StRfWait: begin
        if (bus.mem_rvalid) begin
          refill_d[slice_lo +: BUS_WIDTH] = bus.mem_rdata;
          beat_d  = beat_q + 1'b1;
          state_d = last_beat ? StDone : StRfReq;
        end
      end
      StDone: begin
        ready_mem = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef MEM_TIMEOUT_EN
    // Watchdog counts stalled cycles of the current beat and aborts the transfer
    if (busy && !beat_hs) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = StDone;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

endmodule
